// File: rtl/vermibus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vermibus_arbiter
// Purpose  : Two-master / one-slave arbiter for the Vermibus valid/ready bus.
//            Registered round-robin arbitration; the grant is held until the
//            transfer completes, and the granted master's request path is a
//            combinational pass-through to the slave.
// Optional : `define VERMIBUS_ARB_TIMEOUT_EN to build a wait counter that
//            forces completion after TIMEOUT_CYCLES stalled cycles.
// Ports    :
//   clk, reset                 clock, asynchronous active-low reset
//   m0_* / m1_*                master request (valid/address/wstrobe/wdata)
//                              and response (ready/rdata)
//   s_*                        slave request and response
//   grant[1:0]                 one-hot current owner, 00 = idle
//   timeout                    one-cycle pulse on a forced completion
// Revision : 1.0 - initial release
// ============================================================================
module vermibus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_address,
  input  logic [3:0]  m0_wstrobe,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_address,
  input  logic [3:0]  m1_wstrobe,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_address,
  output logic [3:0]  s_wstrobe,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;        // most recently served master
  logic   w_granted;
  logic   w_sel1;        // current owner is master 1
  logic   w_g_valid;     // owner's valid
  logic   w_timeout;
  logic   w_done;        // transfer completes on this edge

  assign w_granted = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);
  assign w_sel1    = (r_state == ST_GRANT1);
  assign w_g_valid = w_sel1 ? m1_valid : m0_valid;
  assign w_done    = w_granted && w_g_valid && (s_ready || w_timeout);

  generate
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("vermibus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end
  endgenerate

`ifdef VERMIBUS_ARB_TIMEOUT_EN
  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_wait_cnt;
  logic        w_grant_entry;

  // A new ownership period starts whenever the next state is a grant state
  // different from the current one (IDLE->GRANTx or GRANTx->GRANTy).
  assign w_grant_entry = (w_next != ST_IDLE) && (w_next != r_state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= 16'd0;
    end else if (w_grant_entry) begin
      r_wait_cnt <= 16'd0;
    end else if (w_granted && !s_ready) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  // A request abandoned by its master is a protocol violation, not a stall,
  // so the forced completion only applies while the owner still requests.
  assign w_timeout = w_granted && w_g_valid && !s_ready && (r_wait_cnt == c_TIMEOUT);
`else
  assign w_timeout = 1'b0;
`endif

  // State and round-robin history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_done) begin
        r_last <= w_sel1;
      end
    end
  end

  // Next-state: the completing master always goes back through IDLE unless
  // the other master is waiting, in which case ownership hands over directly.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_valid && m1_valid) begin
          w_next = r_last ? ST_GRANT0 : ST_GRANT1;
        end else if (m0_valid) begin
          w_next = ST_GRANT0;
        end else if (m1_valid) begin
          w_next = ST_GRANT1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_GRANT0: begin
        if (!m0_valid) begin
          w_next = ST_IDLE;
        end else if (w_done) begin
          w_next = m1_valid ? ST_GRANT1 : ST_IDLE;
        end
      end
      ST_GRANT1: begin
        if (!m1_valid) begin
          w_next = ST_IDLE;
        end else if (w_done) begin
          w_next = m0_valid ? ST_GRANT0 : ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: pass-through from the owner, everything zero when idle
  always_comb begin
    s_valid   = 1'b0;
    s_address = 32'd0;
    s_wstrobe = 4'd0;
    s_wdata   = 32'd0;
    m0_ready  = 1'b0;
    m0_rdata  = 32'd0;
    m1_ready  = 1'b0;
    m1_rdata  = 32'd0;
    grant     = 2'b00;
    timeout   = w_timeout;
    case (r_state)
      ST_GRANT0: begin
        s_valid   = m0_valid && !w_timeout;
        s_address = m0_address;
        s_wstrobe = m0_wstrobe;
        s_wdata   = m0_wdata;
        m0_ready  = s_ready || w_timeout;
        m0_rdata  = w_timeout ? 32'd0 : s_rdata;
        grant     = 2'b01;
      end
      ST_GRANT1: begin
        s_valid   = m1_valid && !w_timeout;
        s_address = m1_address;
        s_wstrobe = m1_wstrobe;
        s_wdata   = m1_wdata;
        m1_ready  = s_ready || w_timeout;
        m1_rdata  = w_timeout ? 32'd0 : s_rdata;
        grant     = 2'b10;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vermibus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vermibus_arbiter
// Purpose  : Directed self-checking bench for vermibus_arbiter. Inputs are
//            driven 1 time unit after the rising edge and outputs are sampled
//            on the falling edge. The slave is either driven by hand
//            (man_ready) or by a small model that readies after 2 wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vermibus_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_address, m1_address;
  logic [3:0]  m0_wstrobe, m1_wstrobe;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_address;
  logic [3:0]  s_wstrobe;
  logic [31:0] s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        timeout;

  logic        man_ready;
  logic        auto_mode;
  logic        auto_ready;
  int          a_wcnt;

  int          n_checks;
  int          n_fails;
  int          completions;
  int          cycles;
  logic [1:0]  exp_grant;

  vermibus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_valid   (m0_valid),
    .m0_address (m0_address),
    .m0_wstrobe (m0_wstrobe),
    .m0_wdata   (m0_wdata),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_address (m1_address),
    .m1_wstrobe (m1_wstrobe),
    .m1_wdata   (m1_wdata),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_address  (s_address),
    .s_wstrobe  (s_wstrobe),
    .s_wdata    (s_wdata),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .grant      (grant),
    .timeout    (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: ready on the third cycle of each ownership period
  assign auto_ready = (grant != 2'b00) && (a_wcnt == 2);
  assign s_ready    = auto_mode ? auto_ready : man_ready;

  always @(posedge clk) begin
    if ((grant == 2'b00) || auto_ready) a_wcnt <= 0;
    else                                a_wcnt <= a_wcnt + 1;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_valid = 1'b0; m0_address = 32'd0; m0_wstrobe = 4'd0; m0_wdata = 32'd0;
    m1_valid = 1'b0; m1_address = 32'd0; m1_wstrobe = 4'd0; m1_wdata = 32'd0;
    man_ready = 1'b0; auto_mode = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    a_wcnt   = 0;
    reset    = 1'b0;
    clear_inputs();
    // Drive activity during reset: outputs must still be all zero
    m0_valid = 1'b1; m0_address = 32'h10; man_ready = 1'b1; s_rdata = 32'hDEADBEEF;
    #2;
    check_value("rst_s_valid",  32'(s_valid),  32'd0);
    check_value("rst_grant",    32'(grant),    32'd0);
    check_value("rst_m0_ready", 32'(m0_ready), 32'd0);
    check_value("rst_m0_rdata", m0_rdata,      32'd0);
    check_value("rst_timeout",  32'(timeout),  32'd0);
    clear_inputs();
    @(posedge clk);
    #3 reset = 1'b1;
    next_cycle();

    // ---- Single read, no contention ----
    m0_valid = 1'b1; m0_address = 32'h0000_0010; man_ready = 1'b1; s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check_value("t1_idle_s_valid", 32'(s_valid), 32'd0);
    check_value("t1_idle_grant",   32'(grant),   32'd0);
    next_cycle();
    @(negedge clk);
    check_value("t1_s_valid",   32'(s_valid),  32'd1);
    check_value("t1_s_address", s_address,     32'h0000_0010);
    check_value("t1_grant",     32'(grant),    32'd1);
    check_value("t1_m0_ready",  32'(m0_ready), 32'd1);
    check_value("t1_m0_rdata",  m0_rdata,      32'hDEADBEEF);
    check_value("t1_m1_ready",  32'(m1_ready), 32'd0);
    next_cycle();
    m0_valid = 1'b0;
    @(negedge clk);
    check_value("t1_after_grant",   32'(grant),    32'd0);
    check_value("t1_after_s_valid", 32'(s_valid),  32'd0);
    check_value("t1_after_m0_rdy",  32'(m0_ready), 32'd0);

    // ---- Tie after reset ----
    apply_reset();
    m0_valid = 1'b1; m0_address = 32'h100;
    m1_valid = 1'b1; m1_address = 32'h200;
    man_ready = 1'b1; s_rdata = 32'h1111_2222;
    @(negedge clk);
    check_value("t2_idle_grant", 32'(grant), 32'd0);
    next_cycle();
    @(negedge clk);
    check_value("t2_first_grant", 32'(grant),    32'd1);
    check_value("t2_first_addr",  s_address,     32'h100);
    check_value("t2_m0_ready",    32'(m0_ready), 32'd1);
    check_value("t2_m1_ready",    32'(m1_ready), 32'd0);
    check_value("t2_m1_rdata",    m1_rdata,      32'd0);
    next_cycle();
    m0_valid = 1'b0;
    @(negedge clk);
    check_value("t2_handover_grant", 32'(grant),    32'd2);
    check_value("t2_handover_addr",  s_address,     32'h200);
    check_value("t2_m1_ready_b",     32'(m1_ready), 32'd1);
    check_value("t2_m1_rdata_b",     m1_rdata,      32'h1111_2222);
    check_value("t2_m0_ready_b",     32'(m0_ready), 32'd0);
    next_cycle();
    m1_valid = 1'b0;
    @(negedge clk);
    check_value("t2_idle_again", 32'(grant), 32'd0);
    next_cycle();
    m0_valid = 1'b1; m1_valid = 1'b1;
    @(negedge clk);
    check_value("t2_latency", 32'(grant), 32'd0);
    next_cycle();
    @(negedge clk);
    check_value("t2_second_tie", 32'(grant), 32'd1);
    next_cycle();
    m0_valid = 1'b0;
    @(negedge clk);
    check_value("t2_second_handover", 32'(grant), 32'd2);
    next_cycle();
    m1_valid = 1'b0;
    @(negedge clk);
    check_value("t2_end_idle", 32'(grant), 32'd0);

    // ---- Fairness: both masters always requesting ----
    apply_reset();
    s_rdata = 32'hCAFE_0000;
    m0_valid = 1'b1; m1_valid = 1'b1; auto_mode = 1'b1;
    exp_grant = 2'b01;
    completions = 0;
    cycles = 0;
    while ((completions < 16) && (cycles < 200)) begin
      @(negedge clk);
      cycles++;
      check_value("t3_m0_ready_ungranted", 32'(m0_ready & ~grant[0]), 32'd0);
      check_value("t3_m1_ready_ungranted", 32'(m1_ready & ~grant[1]), 32'd0);
      if (grant == 2'b01) check_value("t3_m1_rdata_g0", m1_rdata, 32'd0);
      if (grant == 2'b10) check_value("t3_m0_rdata_g1", m0_rdata, 32'd0);
      if (m0_ready || m1_ready) begin
        check_value("t3_order", 32'(grant), 32'(exp_grant));
        exp_grant = {exp_grant[0], exp_grant[1]};
        completions++;
      end
      next_cycle();
    end
    check_value("t3_completions", completions, 32'd16);
    clear_inputs();
    @(negedge clk);
    check_value("t3_abandon_s_valid", 32'(s_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check_value("t3_abandon_idle", 32'(grant), 32'd0);
    next_cycle();

    // ---- Write pass-through from master 1 ----
    m1_valid = 1'b1; m1_address = 32'h1000_0000; m1_wstrobe = 4'b0011; m1_wdata = 32'h1234_5678;
    man_ready = 1'b0; s_rdata = 32'h55AA_55AA;
    @(negedge clk);
    check_value("t4_idle_s_valid", 32'(s_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check_value("t4_grant",     32'(grant),     32'd2);
    check_value("t4_s_valid",   32'(s_valid),   32'd1);
    check_value("t4_s_address", s_address,      32'h1000_0000);
    check_value("t4_s_wstrobe", 32'(s_wstrobe), 32'h3);
    check_value("t4_s_wdata",   s_wdata,        32'h1234_5678);
    check_value("t4_m1_stall",  32'(m1_ready),  32'd0);
    check_value("t4_m0_ready",  32'(m0_ready),  32'd0);
    next_cycle();
    man_ready = 1'b1;
    @(negedge clk);
    check_value("t4_m1_ready",   32'(m1_ready), 32'd1);
    check_value("t4_m0_ready_b", 32'(m0_ready), 32'd0);
    check_value("t4_m0_rdata",   m0_rdata,      32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_value("t4_end_idle", 32'(grant), 32'd0);
    next_cycle();

    // ---- Reset mid-transaction ----
    m1_valid = 1'b1; m1_address = 32'h300; man_ready = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check_value("t5_grant1", 32'(grant), 32'd2);
    #2 reset = 1'b0; man_ready = 1'b1;
    #1;
    check_value("t5_rst_s_valid",  32'(s_valid),  32'd0);
    check_value("t5_rst_grant",    32'(grant),    32'd0);
    check_value("t5_rst_m1_ready", 32'(m1_ready), 32'd0);
    check_value("t5_rst_m1_rdata", m1_rdata,      32'd0);
    clear_inputs();
    @(posedge clk);
    #3 reset = 1'b1;
    next_cycle();
    m0_valid = 1'b1; m1_valid = 1'b1; man_ready = 1'b1;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check_value("t5_tie_after_reset", 32'(grant), 32'd1);
    next_cycle();
    m0_valid = 1'b0;
    @(negedge clk);
    check_value("t5_then_m1", 32'(grant), 32'd2);
    next_cycle();
    clear_inputs();

    // ---- Stalled slave ----
    apply_reset();
    m0_valid = 1'b1; m0_address = 32'h40; man_ready = 1'b0; s_rdata = 32'h7777_7777;
    @(negedge clk);
    check_value("t6_idle", 32'(grant), 32'd0);
`ifdef VERMIBUS_ARB_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k == 2) m1_valid = 1'b1;
      @(negedge clk);
      check_value("t6_wait_grant",   32'(grant),    32'd1);
      check_value("t6_wait_s_valid", 32'(s_valid),  32'd1);
      check_value("t6_wait_m0_rdy",  32'(m0_ready), 32'd0);
      check_value("t6_wait_timeout", 32'(timeout),  32'd0);
    end
    next_cycle();
    @(negedge clk);
    check_value("t6_to_m0_ready", 32'(m0_ready), 32'd1);
    check_value("t6_to_m0_rdata", m0_rdata,      32'd0);
    check_value("t6_to_pulse",    32'(timeout),  32'd1);
    check_value("t6_to_s_valid",  32'(s_valid),  32'd0);
    next_cycle();
    m0_valid = 1'b0;
    @(negedge clk);
    check_value("t6_next_grant",   32'(grant),   32'd2);
    check_value("t6_pulse_end",    32'(timeout), 32'd0);
    check_value("t6_m1_s_valid",   32'(s_valid), 32'd1);
    next_cycle();
    man_ready = 1'b1;
    @(negedge clk);
    check_value("t6_m1_ready", 32'(m1_ready), 32'd1);
    next_cycle();
    clear_inputs();
`else
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      @(negedge clk);
      check_value("t6_hold_grant",   32'(grant),    32'd1);
      check_value("t6_hold_m0_rdy",  32'(m0_ready), 32'd0);
      check_value("t6_hold_timeout", 32'(timeout),  32'd0);
    end
    apply_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vermibus_arbiter.md
Name: vermibus_arbiter

Overview:
- Two-master, one-slave arbiter for the Vermibus valid/ready protocol. Lets the CPU (master 0) and a second requester (master 1, e.g. DMA or debug loader) share one slave port, typically the RAM or the device decoder in a benchmark/SoC top.
- Uses registered round-robin arbitration with the grant held until the transaction completes.
- Once granted, the data/address path is a combinational pass-through.

Parameters:
- TIMEOUT_CYCLES, default 256: wait cycles without s_ready before a forced completion. Used only with the optional feature; legal range 1..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m0_valid  in  1  master 0 request
- m0_address  in  32  master 0 byte address
- m0_wstrobe  in  4  master 0 byte write enables (0 = read)
- m0_wdata  in  32  master 0 write data
- m0_ready  out  1  master 0 transfer done
- m0_rdata  out  32  master 0 read data
- m1_valid, m1_address, m1_wstrobe, m1_wdata, m1_ready, m1_rdata: same as m0_* for master 1
- s_valid  out  1  slave request
- s_address  out  32  slave address
- s_wstrobe  out  4  slave write enables
- s_wdata  out  32  slave write data
- s_ready  in  1  slave transfer done (may be combinational from s_valid)
- s_rdata  in  32  slave read data
- grant  out  2  one-hot current owner (00 = idle)
- timeout  out  1  one-cycle pulse on forced completion

Behaviour:
- State machine: IDLE, GRANT0, GRANT1. A register `last` holds the most recently served master.
- Reset (reset=0, asynchronous): state=IDLE, last=1 so master 0 wins the first tie, wait counter=0. While in reset, every output is 0: s_valid, s_address, s_wstrobe, s_wdata, m0/m1_ready, m0/m1_rdata, grant, timeout.
- IDLE: all outputs 0. On the rising edge:
  - only m0_valid → GRANT0; only m1_valid → GRANT1
  - both → the master != last
  - none → stay in IDLE
- Arbitration latency: a request that arrives in IDLE at cycle t sees s_valid at cycle t+1. There is no combinational path from m*_valid to s_valid while in IDLE.
- GRANTg, combinational:
  - s_valid/s_address/s_wstrobe/s_wdata = mg_*
  - mg_ready = s_ready; mg_rdata = s_rdata
  - the other master's ready = 0 and rdata = 0
  - grant[g] = 1
- Completion: the cycle in GRANTg where s_valid && s_ready.
  - On that edge last <= g.
  - If the other master's valid=1, go directly to GRANT(other) with no idle bubble. Otherwise go to IDLE.
  - The completing master always returns through IDLE. A held-high valid after ready counts as a new request and is re-arbitrated. Maximum throughput for one master is therefore one transfer per 2 cycles; alternating masters reach 1 per cycle.
- Grant is never pre-empted: a request from the other master mid-transaction waits.
- Protocol violation: if the granted master drops valid before ready, go to IDLE. last is not updated and no slave access is counted.
- Reset asserted mid-transaction: immediate return to IDLE and s_valid drops asynchronously. The slave must tolerate an abandoned request.
- Reads and writes are treated identically. wstrobe is passed through unmodified.

Optional Feature:
- Macro VERMIBUS_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to any GRANT state and increments each granted cycle with s_ready=0.
  - In the granted cycle where counter == TIMEOUT_CYCLES and s_ready=0, the arbiter forces mg_ready=1, mg_rdata=32'h0000_0000 and s_valid=0, and pulses timeout=1.
  - That cycle is then handled as a normal completion, including the `last` update and the next-state rule.
- Not defined: no counter is built; the timeout port is tied to 0; a stalled slave blocks the bus indefinitely.

Test Plan:
- Single read, no contention: reset released, m0 read of 0x0000_0010 with the slave returning ready the same cycle and rdata=0xDEADBEEF → s_valid high one cycle after m0_valid, m0_ready=1 with m0_rdata=0xDEADBEEF, grant 01 then 00.
- Tie after reset: m0 and m1 request in the same cycle → m0 served first, m1 granted on the edge of m0's completion with no idle cycle; the next simultaneous tie goes to m0 (last=1).
- Fairness: both masters hold valid continuously for 8 transfers each, slave ready after 2 wait cycles → grants strictly alternate 0,1,0,1…; neither master ever sees ready while not granted; m1_rdata = 0 during GRANT0.
- Write pass-through: m1 writes wstrobe=4'b0011, wdata=0x1234_5678 to 0x1000_0000 → slave sees identical address, wstrobe and wdata; m0_ready stays 0 throughout.
- Reset mid-transaction: assert reset while in GRANT1 with the slave stalled → s_valid, grant and m1_ready drop to 0 immediately; after release, the first tie goes to m0.
- VERMIBUS_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and a slave that never readies → m0_ready=1, m0_rdata=0 and timeout=1 on the 5th granted cycle; s_valid=0 in that cycle; a pending m1 request is granted next.
